alu_seq: RTL and testbench

Parametrised, registered successor to the team's 8-bit ALU. Computes arithmetic, logic, shift/rotate and multiply operations on `WIDTH`-bit operands, and produces status flags. Operations are started with a start/busy/done handshake. Single-cycle operations complete in one clock; multiply is a multi-cycle shift-add operation. It sits between the register file and the writeback path and replaces the combinational ALU plus its inverted-clock output mux.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_mul_seq.sv | 40 ++++
 rtl/alu_seq.sv | 159 +++++++++++++++
 tb/tb_alu_seq.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and flag indices for alu_seq.
// Imported by the interface, the multiplier and the top level.
package alu_seq_pkg;

  localparam logic [3:0] OP_PASSA = 4'b0000;
  localparam logic [3:0] OP_INC   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_ADC   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_DEC   = 4'b0101;
  localparam logic [3:0] OP_PASSB = 4'b0110;
  localparam logic [3:0] OP_MUL   = 4'b0111;
  localparam logic [3:0] OP_AND   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_NOT   = 4'b1011;
  localparam logic [3:0] OP_SHL   = 4'b1100;
  localparam logic [3:0] OP_SHR   = 4'b1101;
  localparam logic [3:0] OP_ROL   = 4'b1110;
  localparam logic [3:0] OP_ROR   = 4'b1111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the register file side and alu_seq.
// master drives requests; slave (the ALU) returns registered results.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             alu_start;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_c_in;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] alu_y_hi;
  logic [3:0]       alu_flags;
  logic             alu_busy;
  logic             alu_done;

  modport master (
    output alu_start, alu_sel, alu_a, alu_b, alu_c_in,
    input  alu_y, alu_y_hi, alu_flags, alu_busy, alu_done
  );

  modport slave (
    input  alu_start, alu_sel, alu_a, alu_b, alu_c_in,
    output alu_y, alu_y_hi, alu_flags, alu_busy, alu_done
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Serial shift-add multiplier, one partial product per step_en cycle.
// product shows the value after this cycle's step so the caller can register it on last.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               step_en,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_p;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_step;

  // upper half accumulates, lower half holds the unconsumed multiplier bits
  assign w_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]}
                + (r_p[0] ? {1'b0, r_a} : '0);
  assign w_step = {w_sum, r_p[WIDTH-1:1]};

  assign product = w_step;
  assign last    = step_en && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (load) begin
      r_a   <= a;
      r_p   <= {{WIDTH{1'b0}}, b};
      r_cnt <= '0;
    end else if (step_en) begin
      r_p   <= w_step;
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake and serial multiply.
// Single-cycle ops finish in one clock; MUL takes WIDTH steps.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     alu_clk,
  input  logic     alu_rst,
  alu_seq_if.slave bus
);
  localparam int M = WIDTH - 1;

  alu_state_t r_state, w_state_nxt;

  logic [WIDTH-1:0]   r_y, r_y_hi;
  logic [3:0]         r_flags;
  logic               r_done;

  logic [WIDTH-1:0]   w_a, w_b;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH:0]     w_ext;
  logic               w_c, w_v;
  logic               w_load, w_step, w_upd, w_last;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_y_nxt, w_yhi_nxt;
  logic [3:0]         w_flags_nxt;

  assign w_a = bus.alu_a;
  assign w_b = bus.alu_b;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (alu_clk),
    .load    (w_load),
    .a       (w_a),
    .b       (w_b),
    .step_en (w_step),
    .product (w_prod),
    .last    (w_last)
  );

  always_comb begin
    w_res = '0;
    w_ext = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (bus.alu_sel)
      OP_PASSA: w_res = w_a;
      OP_INC: begin
        w_ext = {1'b0, w_a} + (WIDTH+1)'(1);
        w_res = w_ext[M:0];
        w_c   = w_ext[WIDTH];
        w_v   = ~w_a[M] & w_res[M];
      end
      OP_ADD, OP_ADC: begin
        w_ext = {1'b0, w_a} + {1'b0, w_b}
              + (WIDTH+1)'(bus.alu_sel == OP_ADC && bus.alu_c_in);
        w_res = w_ext[M:0];
        w_c   = w_ext[WIDTH];
        w_v   = (w_a[M] == w_b[M]) && (w_res[M] != w_a[M]);
      end
      OP_SUB: begin
        w_ext = {1'b0, w_a} - {1'b0, w_b};
        w_res = w_ext[M:0];
        w_c   = w_ext[WIDTH];
        w_v   = (w_a[M] != w_b[M]) && (w_res[M] != w_a[M]);
      end
      OP_DEC: begin
        w_ext = {1'b0, w_a} - (WIDTH+1)'(1);
        w_res = w_ext[M:0];
        w_c   = w_ext[WIDTH];
        w_v   = w_a[M] & ~w_res[M];
      end
      OP_PASSB: w_res = w_b;
      OP_MUL:   w_res = '0;
      OP_AND:   w_res = w_a & w_b;
      OP_OR:    w_res = w_a | w_b;
      OP_XOR:   w_res = w_a ^ w_b;
      OP_NOT:   w_res = ~w_a;
      OP_SHL: begin
        w_res = {w_a[M-1:0], 1'b0};
        w_c   = w_a[M];
      end
      OP_SHR: begin
        w_res = {1'b0, w_a[M:1]};
        w_c   = w_a[0];
      end
      OP_ROL: begin
        w_res = {w_a[M-1:0], w_a[M]};
        w_c   = w_a[M];
      end
      OP_ROR: begin
        w_res = {w_a[0], w_a[M:1]};
        w_c   = w_a[0];
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_upd       = 1'b0;
    w_y_nxt     = '0;
    w_yhi_nxt   = '0;
    w_flags_nxt = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.alu_start && bus.alu_sel == OP_MUL) begin
          w_load      = 1'b1;
          w_state_nxt = ST_MUL;
        end else if (bus.alu_start) begin
          w_upd               = 1'b1;
          w_y_nxt             = w_res;
          w_flags_nxt[FLAG_Z] = (w_res == '0);
          w_flags_nxt[FLAG_N] = w_res[M];
          w_flags_nxt[FLAG_C] = w_c;
          w_flags_nxt[FLAG_V] = w_v;
        end
      end
      ST_MUL: begin
        w_step = 1'b1;
        if (w_last) begin
          w_upd               = 1'b1;
          w_state_nxt         = ST_IDLE;
          w_y_nxt             = w_prod[M:0];
          w_yhi_nxt           = w_prod[2*WIDTH-1:WIDTH];
          w_flags_nxt[FLAG_Z] = (w_prod == '0);
          w_flags_nxt[FLAG_N] = w_prod[2*WIDTH-1];
          w_flags_nxt[FLAG_C] = (w_prod[2*WIDTH-1:WIDTH] != '0);
        end
      end
    endcase
  end

  always_ff @(posedge alu_clk) begin
    if (alu_rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_y_hi  <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_upd;
      if (w_upd) begin
        r_y     <= w_y_nxt;
        r_y_hi  <= w_yhi_nxt;
        r_flags <= w_flags_nxt;
      end
    end
  end

  assign bus.alu_y     = r_y;
  assign bus.alu_y_hi  = r_y_hi;
  assign bus.alu_flags = r_flags;
  assign bus.alu_done  = r_done;
  assign bus.alu_busy  = (r_state == ST_MUL);
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH = 8.
// Flags are written {Z,N,C,V}; inputs change 1 ns after the rising edge.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic alu_clk = 1'b0;
  logic alu_rst = 1'b1;
  int   n_chk   = 0;
  int   n_fail  = 0;

  alu_seq_if #(.WIDTH(8)) bus_if ();

  alu_seq #(.WIDTH(8)) dut (
    .alu_clk (alu_clk),
    .alu_rst (alu_rst),
    .bus     (bus_if)
  );

  always #5 alu_clk = ~alu_clk;

  task automatic tick;
    @(posedge alu_clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic ci);
    bus_if.alu_start = s;
    bus_if.alu_sel   = op;
    bus_if.alu_a     = a;
    bus_if.alu_b     = b;
    bus_if.alu_c_in  = ci;
  endtask

  task automatic test_reset;
    drive(1'b0, OP_PASSA, 8'h00, 8'h00, 1'b0);
    alu_rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({bus_if.alu_y, bus_if.alu_y_hi} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_y: got %h/%h want 00/00",
               bus_if.alu_y, bus_if.alu_y_hi);
    end
    n_chk++;
    if ({bus_if.alu_flags, bus_if.alu_busy, bus_if.alu_done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: flags/busy/done got %b/%b/%b want 0000/0/0",
               bus_if.alu_flags, bus_if.alu_busy, bus_if.alu_done);
    end
    alu_rst = 1'b0;
    tick();
  endtask

  task automatic test_add;
    drive(1'b1, OP_ADD, 8'hFF, 8'h01, 1'b1);
    tick();
    drive(1'b0, OP_PASSA, 8'h00, 8'h00, 1'b0);
    n_chk++;
    if (bus_if.alu_y !== 8'h00 || bus_if.alu_flags !== 4'b1010) begin
      n_fail++;
      $display("FAIL add: got y=%h f=%b want y=00 f=1010",
               bus_if.alu_y, bus_if.alu_flags);
    end
    n_chk++;
    if (bus_if.alu_done !== 1'b1 || bus_if.alu_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL add_hs: got done=%b busy=%b want 1/0",
               bus_if.alu_done, bus_if.alu_busy);
    end
    tick();
    n_chk++;
    if (bus_if.alu_done !== 1'b0 || bus_if.alu_y !== 8'h00) begin
      n_fail++;
      $display("FAIL add_hold: got done=%b y=%h want 0/00",
               bus_if.alu_done, bus_if.alu_y);
    end
  endtask

  task automatic test_sub_dec;
    drive(1'b1, OP_SUB, 8'h80, 8'h01, 1'b0);
    tick();
    n_chk++;
    if (bus_if.alu_y !== 8'h7F || bus_if.alu_flags !== 4'b0001) begin
      n_fail++;
      $display("FAIL sub: got y=%h f=%b want y=7f f=0001",
               bus_if.alu_y, bus_if.alu_flags);
    end
    drive(1'b1, OP_DEC, 8'h00, 8'h55, 1'b1);
    tick();
    drive(1'b0, OP_PASSA, 8'h00, 8'h00, 1'b0);
    n_chk++;
    if (bus_if.alu_y !== 8'hFF || bus_if.alu_flags !== 4'b0110) begin
      n_fail++;
      $display("FAIL dec: got y=%h f=%b want y=ff f=0110",
               bus_if.alu_y, bus_if.alu_flags);
    end
    tick();
  endtask

  task automatic test_mul_ignore;
    int busy_cnt = 0;
    drive(1'b1, OP_MUL, 8'h0F, 8'h11, 1'b0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      if (bus_if.alu_busy === 1'b1 && bus_if.alu_done === 1'b0)
        busy_cnt++;
      if (i == 3) drive(1'b1, OP_MUL, 8'h01, 8'h01, 1'b0);
      else        drive(1'b0, OP_PASSA, 8'h00, 8'h00, 1'b0);
      tick();
    end
    n_chk++;
    if (busy_cnt != 8) begin
      n_fail++;
      $display("FAIL mul_busy: got %0d busy cycles want 8", busy_cnt);
    end
    n_chk++;
    if (bus_if.alu_done !== 1'b1 || bus_if.alu_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_done: got done=%b busy=%b want 1/0",
               bus_if.alu_done, bus_if.alu_busy);
    end
    n_chk++;
    if ({bus_if.alu_y_hi, bus_if.alu_y} !== 16'h00FF ||
        bus_if.alu_flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL mul_res: got %h%h f=%b want 00ff f=0000",
               bus_if.alu_y_hi, bus_if.alu_y, bus_if.alu_flags);
    end
    tick();
    n_chk++;
    if (bus_if.alu_busy !== 1'b0 || bus_if.alu_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_after: got busy=%b done=%b want 0/0",
               bus_if.alu_busy, bus_if.alu_done);
    end
  endtask

  task automatic test_mul_max;
    int cyc = 0;
    drive(1'b1, OP_MUL, 8'hFF, 8'hFF, 1'b0);
    tick();
    drive(1'b0, OP_PASSA, 8'h00, 8'h00, 1'b0);
    while (bus_if.alu_done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    n_chk++;
    if (cyc != 8) begin
      n_fail++;
      $display("FAIL mul_lat: got done after %0d extra cycles want 8", cyc);
    end
    n_chk++;
    if ({bus_if.alu_y_hi, bus_if.alu_y} !== 16'hFE01 ||
        bus_if.alu_flags !== 4'b0110) begin
      n_fail++;
      $display("FAIL mul_max: got %h%h f=%b want fe01 f=0110",
               bus_if.alu_y_hi, bus_if.alu_y, bus_if.alu_flags);
    end
    tick();
  endtask

  task automatic test_shift_logic;
    drive(1'b1, OP_ROR, 8'h01, 8'h00, 1'b1);
    tick();
    n_chk++;
    if ({bus_if.alu_y, bus_if.alu_flags} !== {8'h80, 4'b0110} ||
        bus_if.alu_y_hi !== 8'h00) begin
      n_fail++;
      $display("FAIL ror: got y=%h f=%b hi=%h want 80 0110 00",
               bus_if.alu_y, bus_if.alu_flags, bus_if.alu_y_hi);
    end
    drive(1'b1, OP_SHL, 8'h81, 8'h00, 1'b0);
    tick();
    n_chk++;
    if ({bus_if.alu_y, bus_if.alu_flags} !== {8'h02, 4'b0010}) begin
      n_fail++;
      $display("FAIL shl: got y=%h f=%b want 02 0010",
               bus_if.alu_y, bus_if.alu_flags);
    end
    drive(1'b1, OP_XOR, 8'h5A, 8'h5A, 1'b1);
    tick();
    n_chk++;
    if ({bus_if.alu_y, bus_if.alu_flags} !== {8'h00, 4'b1000}) begin
      n_fail++;
      $display("FAIL xor: got y=%h f=%b want 00 1000",
               bus_if.alu_y, bus_if.alu_flags);
    end
    drive(1'b1, OP_ROL, 8'h80, 8'h00, 1'b0);
    tick();
    n_chk++;
    if ({bus_if.alu_y, bus_if.alu_flags} !== {8'h01, 4'b0010}) begin
      n_fail++;
      $display("FAIL rol: got y=%h f=%b want 01 0010",
               bus_if.alu_y, bus_if.alu_flags);
    end
    drive(1'b1, OP_SHR, 8'h81, 8'h00, 1'b0);
    tick();
    drive(1'b0, OP_PASSA, 8'h00, 8'h00, 1'b0);
    n_chk++;
    if ({bus_if.alu_y, bus_if.alu_flags} !== {8'h40, 4'b0010}) begin
      n_fail++;
      $display("FAIL shr: got y=%h f=%b want 40 0010",
               bus_if.alu_y, bus_if.alu_flags);
    end
    tick();
  endtask

  task automatic test_reset_mid_mul;
    drive(1'b1, OP_MUL, 8'hFF, 8'hFF, 1'b0);
    tick();
    drive(1'b0, OP_PASSA, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    alu_rst = 1'b1;
    drive(1'b1, OP_ADD, 8'h01, 8'h01, 1'b0);
    tick();
    n_chk++;
    if ({bus_if.alu_busy, bus_if.alu_done, bus_if.alu_flags} !== 6'b0 ||
        {bus_if.alu_y, bus_if.alu_y_hi} !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_mul: got b=%b d=%b f=%b y=%h hi=%h want zeros",
               bus_if.alu_busy, bus_if.alu_done, bus_if.alu_flags,
               bus_if.alu_y, bus_if.alu_y_hi);
    end
    alu_rst = 1'b0;
    drive(1'b1, OP_ADC, 8'h01, 8'h01, 1'b1);
    tick();
    drive(1'b0, OP_PASSA, 8'h00, 8'h00, 1'b0);
    n_chk++;
    if ({bus_if.alu_done, bus_if.alu_y, bus_if.alu_flags} !==
        {1'b1, 8'h03, 4'b0000}) begin
      n_fail++;
      $display("FAIL adc: got d=%b y=%h f=%b want 1 03 0000",
               bus_if.alu_done, bus_if.alu_y, bus_if.alu_flags);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    drive(1'b1, OP_ADD, 8'h10, 8'h20, 1'b1);
    tick();
    n_chk++;
    if ({bus_if.alu_done, bus_if.alu_y, bus_if.alu_flags} !==
        {1'b1, 8'h30, 4'b0000}) begin
      n_fail++;
      $display("FAIL b2b_add: got d=%b y=%h f=%b want 1 30 0000",
               bus_if.alu_done, bus_if.alu_y, bus_if.alu_flags);
    end
    drive(1'b1, OP_AND, 8'hCC, 8'hAA, 1'b0);
    tick();
    n_chk++;
    if ({bus_if.alu_done, bus_if.alu_y, bus_if.alu_flags} !==
        {1'b1, 8'h88, 4'b0100}) begin
      n_fail++;
      $display("FAIL b2b_and: got d=%b y=%h f=%b want 1 88 0100",
               bus_if.alu_done, bus_if.alu_y, bus_if.alu_flags);
    end
    drive(1'b1, OP_NOT, 8'h0F, 8'h00, 1'b0);
    tick();
    drive(1'b0, OP_PASSA, 8'h00, 8'h00, 1'b0);
    n_chk++;
    if ({bus_if.alu_done, bus_if.alu_y, bus_if.alu_flags} !==
        {1'b1, 8'hF0, 4'b0100}) begin
      n_fail++;
      $display("FAIL b2b_not: got d=%b y=%h f=%b want 1 f0 0100",
               bus_if.alu_done, bus_if.alu_y, bus_if.alu_flags);
    end
    tick();
    n_chk++;
    if (bus_if.alu_done !== 1'b0 || bus_if.alu_y !== 8'hF0) begin
      n_fail++;
      $display("FAIL b2b_end: got d=%b y=%h want 0 f0",
               bus_if.alu_done, bus_if.alu_y);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_dec();
    test_mul_ignore();
    test_mul_max();
    test_shift_logic();
    test_reset_mid_mul();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
